// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: sequences MULT/MULTU/DIV/DIVU over a registered multiplier and restoring divider, owns HI/LO
module muldiv_hilo_ctrl #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall_req,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nx;
   logic [5:0] cnt;
   logic [31:0] a_reg, b_reg;
   logic [63:0] res;
   logic sa, sb, sgn, is_div;
   logic start, mt_ok, sgn_op, neg_q, step_ge;
   logic [32:0] step_tmp, step_diff;
   logic [63:0] prod_fix;
   logic [31:0] q_fix, r_fix;
   assign start  = req_valid & ~flush & (state == IDLE) & (op >= 3'd1) & (op <= 3'd4);
   assign mt_ok  = req_valid & ~flush & (state == IDLE);
   assign sgn_op = (op == 3'd1) | (op == 3'd3);
   // res holds {remainder, quotient} while dividing and the raw product while multiplying
   always_comb begin
      step_tmp  = {res[63:32], res[31]};
      step_diff = step_tmp - {1'b0, b_reg};
      step_ge   = ~step_diff[32];
      neg_q     = sgn & (sa ^ sb);
      prod_fix  = neg_q ? -res : res;
      q_fix     = neg_q ? -res[31:0] : res[31:0];
      r_fix     = (sgn & sa) ? -res[63:32] : res[63:32];
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else
         case (state)
            IDLE:    if (start) state_nx = (op >= 3'd3) ? DIV : MUL;
            MUL:     if (cnt == 6'(MUL_CYCLES - 1)) state_nx = DONE;
            DIV:     if (cnt == 6'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end
   always_comb begin
      stall_req = ~flush & (start | (state == MUL) | (state == DIV));
      busy      = state != IDLE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         res    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         sgn    <= 1'b0;
         is_div <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         cnt <= (state == IDLE) ? 6'd0 : cnt + 6'd1;
         if (start) begin
            sgn    <= sgn_op;
            is_div <= op >= 3'd3;
            sa     <= sgn_op & src_a[31];
            sb     <= sgn_op & src_b[31];
            a_reg  <= (sgn_op & src_a[31]) ? -src_a : src_a;
            b_reg  <= (sgn_op & src_b[31]) ? -src_b : src_b;
            res    <= {32'd0, (sgn_op & src_a[31]) ? -src_a : src_a};
         end
         if (state == MUL) res <= 64'(a_reg) * 64'(b_reg);
         if (state == DIV) res <= {step_ge ? step_diff[31:0] : step_tmp[31:0], res[30:0], step_ge};
         if (state == DONE && !flush) begin
            hi_out <= is_div ? r_fix : prod_fix[63:32];
            lo_out <= is_div ? q_fix : prod_fix[31:0];
         end
         if (mt_ok && op == 3'd5) hi_out <= src_a;
         if (mt_ok && op == 3'd6) lo_out <= src_a;
      end
   end
endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Multi-cycle controller for the HI/LO datapath: sequences MULT/MULTU over a registered multiplier and DIV/DIVU over a radix-2 restoring divider, and owns the architectural HI/LO registers. Sits in the execute stage beside the ALU. It raises a stall to hold the pipeline while an operation is in flight and aborts cleanly on exception flush. MTHI/MTLO write HI/LO in a single cycle.

## Interface
- MUL_CYCLES, 2, cycles spent in MUL state; legal range 1..8.
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute-stage instruction valid (not a bubble).
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- src_a  in  32  rs value; dividend / multiplicand / MTHI-MTLO data.
- src_b  in  32  rt value; divisor / multiplier.
- flush  in  1  exception/ERET flush of E stage; cancels everything.
- stall_req  out  1  hold F/D/E stages.
- busy  out  1  FSM not IDLE.
- hi_out  out  32  architectural HI.
- lo_out  out  32  architectural LO.

## Operation
- States: IDLE, MUL, DIV, DONE. A 6-bit cycle counter and the latched operands, signs, opcode, and 64-bit result are held in registers.
- start = req_valid & !flush & state==IDLE & op in {001..100}.
- IDLE:
  - On start, latch operands and go to MUL (ops 001/010) or DIV (011/100); counter = 0.
  - For signed ops, latch |src_a|, |src_b| and the sign bits; unsigned ops latch raw values.
  - MTHI/MTLO (req_valid & !flush & IDLE): write hi_out/lo_out with src_a at the edge. No stall.
- MUL: product of the magnitudes is registered. Stay MUL_CYCLES cycles, then DONE.
- DIV: one restoring step per cycle, remainder/quotient shift, 32 cycles, then DONE.
- DONE:
  - Apply sign fixes and write {HI,LO} at the edge leaving DONE, then return to IDLE.
  - op/req_valid are ignored in DONE, because the same instruction is still in E.
- Sign rules:
  - Signed product is negated iff the sign bits differ.
  - Quotient is negated iff the sign bits differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (no trap):
  - Unsigned: LO=0xFFFFFFFF, HI=src_a.
  - Signed: HI=src_a; LO=0xFFFFFFFF if src_a≥0, else 0x00000001.
- flush in any state: next state IDLE, no HI/LO write, result discarded. flush during IDLE also suppresses MTHI/MTLO.
- stall_req = !flush & (start | state==MUL | state==DIV).
- busy = state!=IDLE.

## Timing
- Reset (async, immediate):
  - State IDLE, counter 0.
  - hi_out=lo_out=0, busy=0.
  - stall_req=0, as it is combinational from state/inputs with state IDLE.
- Accept cycle is cycle 0, where stall_req=1 combinationally.
- MULT/MULTU:
  - stall_req high for 1+MUL_CYCLES cycles; DONE at cycle 1+MUL_CYCLES.
  - HI/LO are visible from cycle 2+MUL_CYCLES.
- DIV/DIVU:
  - stall_req high for 33 cycles (0..32); DONE at cycle 33.
  - HI/LO are visible from cycle 34.
- In DONE, stall_req=0 so the instruction advances at that edge. A new muldiv in E can start in the following IDLE cycle (back-to-back, one idle cycle of overlap).
- MTHI/MTLO: hi_out/lo_out updated at the edge ending the cycle, readable next cycle.
- Reset asserted mid-operation: the operation is abandoned, HI/LO are zeroed, and there is no pending write after release.
- flush and a DONE write in the same cycle: flush wins, and HI/LO are unchanged.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0: hi_out/lo_out take those values one cycle later; stall_req stays 0.
- MULT -2 × 3 (MUL_CYCLES=2): stall_req high 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU 0xFFFFFFFF × 0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2: stall_req high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 gives LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. DIVU 5 / 0 gives LO=0xFFFFFFFF, HI=5. DIV -5 / 0 gives LO=1, HI=0xFFFFFFFB.
- Flush at DIV cycle 10 and separately in the DONE cycle: stall_req drops immediately, busy=0 next cycle, and HI/LO keep their prior values.
- Back-to-back DIVU then MULT: the second starts the cycle after DONE, and both results land in the correct order.
